irq_aggregator: RTL and testbench

- Memory-mapped interrupt aggregator that sits directly downstream of the interval timer's irq output and of other peripheral interrupt lines.
- Latches each source as edge- or level-sensitive, masks them, and produces one registered interrupt request to the CPU.
- Provides a priority-encoded "next pending source" register so the ISR can dispatch without scanning.
- 16-bit slave bus: 3-bit word address, chipselect/write_n strobes, one-cycle registered readdata.

---
 rtl/irq_aggregator_if.sv | 16 +
 rtl/irq_aggregator.sv | 95 +++++++++
 tb/tb_irq_aggregator.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/irq_aggregator_if.sv
// Slave bus bundle for the interrupt aggregator: word address, strobes, 16-bit data.
interface irq_aggregator_if;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (output address, output chipselect, output write_n, output writedata,
                    input  readdata);
    modport slave  (input  address, input  chipselect, input  write_n, input  writedata,
                    output readdata);
endinterface

// File: rtl/irq_aggregator.sv
// Interrupt aggregator: synchronises, latches (edge/level), masks and prioritises
// NUM_IRQ sources into one registered CPU interrupt with a memory-mapped register file.
module irq_aggregator #(
    parameter int unsigned NUM_IRQ     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    irq_aggregator_if.slave    bus,
    output logic               irq_out
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = 4;

    localparam logic [2:0] ADDR_PEND  = 3'd0;
    localparam logic [2:0] ADDR_EN    = 3'd1;
    localparam logic [2:0] ADDR_MODE  = 3'd2;
    localparam logic [2:0] ADDR_RAW   = 3'd3;
    localparam logic [2:0] ADDR_NEXT  = 3'd4;
    localparam logic [2:0] ADDR_SSET  = 3'd5;

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] enable_q;
    logic [NUM_IRQ-1:0] edge_mode_q;

    logic [NUM_IRQ-1:0] s;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] wdat;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] sset;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] active;
    logic               any_active;
    logic               wr;
    logic [IDX_W-1:0]   next_idx;
    logic [DATA_W-1:0]  rd_mux;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign wr   = bus.chipselect & ~bus.write_n;
    assign wdat = bus.writedata[NUM_IRQ-1:0];
    assign w1c  = (wr && bus.address == ADDR_PEND) ? wdat : '0;
    assign sset = (wr && bus.address == ADDR_SSET) ? wdat : '0;

    // Edge bits: set (edge or soft-set) wins over W1C. Level bits track s.
    assign pending_d = (edge_mode_q & ((pending_q & ~w1c) | rise | sset))
                     | (~edge_mode_q & s);

    assign active     = pending_q & enable_q;
    assign any_active = |active;

    // Lowest pending+enabled index has the highest priority.
    always_comb begin
        next_idx = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (active[i]) next_idx = IDX_W'(i);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_PEND: rd_mux = DATA_W'(pending_q);
            ADDR_EN:   rd_mux = DATA_W'(enable_q);
            ADDR_MODE: rd_mux = DATA_W'(edge_mode_q);
            ADDR_RAW:  rd_mux = DATA_W'(s);
            ADDR_NEXT: rd_mux = {any_active, (DATA_W-IDX_W-1)'(0), next_idx};
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
            prev_q      <= '0;
            pending_q   <= '0;
            enable_q    <= '0;
            edge_mode_q <= '0;
            bus.readdata <= '0;
            irq_out     <= 1'b0;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
            prev_q    <= s;
            pending_q <= pending_d;
            if (wr && bus.address == ADDR_EN)   enable_q    <= wdat;
            if (wr && bus.address == ADDR_MODE) edge_mode_q <= wdat;
            bus.readdata <= rd_mux;
            irq_out      <= any_active;
        end
    end
endmodule

// File: tb/tb_irq_aggregator.sv
// Directed self-checking bench for irq_aggregator; reads are scored through an expected-value queue.
module tb_irq_aggregator;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] irq_in;
    logic       irq_out;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q [$];
    string       tag_q [$];

    irq_aggregator_if bus ();

    irq_aggregator #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .irq_in  (irq_in),
        .bus     (bus),
        .irq_out (irq_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {15'd0, irq_out}, {15'd0, exp});
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] e, input string t);
        logic [15:0] ev;
        string       et;
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(t);
        tick();
        bus.chipselect = 1'b0;
        ev = exp_q.pop_front();
        et = tag_q.pop_front();
        chk(et, bus.readdata, ev);
    endtask

    initial begin
        reset_n        = 1'b0;
        irq_in         = '0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (3) tick();
        chk_irq("rst_irq", 1'b0);
        chk("rst_readdata", bus.readdata, 16'h0000);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, $sformatf("rst_addr%0d", a));
        chk_irq("rst_irq_after_reads", 1'b0);

        // Edge pulse on bit 0: irq_out three edges after first sample
        wr(3'd1, 16'h0001);
        wr(3'd2, 16'h0001);
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        chk_irq("pulse_k0", 1'b0);
        tick(); chk_irq("pulse_k1", 1'b0);
        tick(); chk_irq("pulse_k2", 1'b0);
        tick(); chk_irq("pulse_k3", 1'b1);
        rd(3'd0, 16'h0001, "pulse_pend");
        wr(3'd0, 16'h0001);
        chk_irq("w1c_irq_1", 1'b1);
        tick(); chk_irq("w1c_irq_2", 1'b0);

        // Level mode on bit 2, W1C ignored while high
        wr(3'd1, 16'h0004);
        wr(3'd2, 16'h0000);
        irq_in = 8'h04;
        tick(); chk_irq("lvl_k0", 1'b0);
        tick(); chk_irq("lvl_k1", 1'b0);
        tick(); chk_irq("lvl_k2", 1'b0);
        tick(); chk_irq("lvl_k3", 1'b1);
        wr(3'd0, 16'h0004);
        rd(3'd0, 16'h0004, "lvl_w1c_no_effect");
        rd(3'd3, 16'h0004, "raw_s");
        repeat (3) begin
            tick(); chk_irq("lvl_hold", 1'b1);
        end
        irq_in = 8'h00;
        tick(); chk_irq("lvl_f0", 1'b1);
        tick(); chk_irq("lvl_f1", 1'b1);
        tick(); chk_irq("lvl_f2", 1'b1);
        tick(); chk_irq("lvl_f3", 1'b0);

        // Edge bits 1 and 5, priority readout
        wr(3'd2, 16'h0022);
        wr(3'd1, 16'h0022);
        irq_in = 8'h22;
        tick();
        irq_in = 8'h00;
        repeat (2) tick();
        rd(3'd4, 16'h8001, "next_both");
        wr(3'd0, 16'h0002);
        rd(3'd4, 16'h8005, "next_bit5");
        wr(3'd0, 16'h0020);
        rd(3'd4, 16'h0000, "next_none");
        chk_irq("edge_clr_irq", 1'b0);

        // Rising edge on bit 3 coincides with W1C of bit 3
        wr(3'd2, 16'h0008);
        wr(3'd1, 16'h0008);
        irq_in = 8'h08;
        tick();
        irq_in = 8'h00;
        tick();
        wr(3'd0, 16'h0008);
        rd(3'd0, 16'h0008, "set_wins");
        wr(3'd0, 16'h0008);
        rd(3'd0, 16'h0000, "w1c_bit3");

        // Soft-set with enable off, then enable
        wr(3'd1, 16'h0000);
        wr(3'd2, 16'h0080);
        wr(3'd5, 16'h0080);
        rd(3'd0, 16'h0080, "sset_pend");
        chk_irq("sset_masked", 1'b0);
        rd(3'd5, 16'h0000, "sset_reads0");
        chk_irq("sset_masked2", 1'b0);
        wr(3'd1, 16'h0080);
        chk_irq("en_irq_1", 1'b0);
        tick(); chk_irq("en_irq_2", 1'b1);
        rd(3'd4, 16'h8007, "next_bit7");
        wr(3'd1, 16'hFFFF);
        rd(3'd1, 16'h00FF, "enable_mask");
        rd(3'd6, 16'h0000, "addr6_zero");
        wr(3'd1, 16'h0080);

        // Edge -> level: pending follows s=0 on the following cycle
        wr(3'd2, 16'h0000);
        tick();
        rd(3'd0, 16'h0000, "mode_to_level");

        // Reset while irq_out is high
        wr(3'd2, 16'h0080);
        wr(3'd5, 16'h0080);
        tick(); chk_irq("pre_rst_irq", 1'b1);
        reset_n = 1'b0;
        tick();
        chk_irq("mid_rst_irq", 1'b0);
        chk("mid_rst_readdata", bus.readdata, 16'h0000);
        reset_n = 1'b1;
        rd(3'd0, 16'h0000, "post_rst_pend");
        rd(3'd1, 16'h0000, "post_rst_en");
        rd(3'd2, 16'h0000, "post_rst_mode");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
